// File: rtl/simd_result_drain_pkg.sv
// Shared constants and state encoding for the simdcore result-drain slice.
package simd_result_drain_pkg;

    localparam int unsigned SIMD_WORD        = 32;
    localparam int unsigned SIMD_LANE_STRIDE = 4;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_RUN  = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_e;

    // Lane index width, kept at least one bit for a single-lane build.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/simd_lane_pick.sv
// Find-first-set over mask bits strictly above cur_lane, or from bit 0 when from_start.
module simd_lane_pick #(
    parameter int unsigned ALUWIDTH = 16,
    parameter int unsigned LW       = 4
) (
    input  logic [ALUWIDTH-1:0] mask,
    input  logic [LW-1:0]       cur_lane,
    input  logic                from_start,
    output logic [LW-1:0]       next_lane,
    output logic                none_left
);

    // Scan downward so the lowest qualifying bit is the last (winning) assignment.
    always_comb begin
        next_lane = '0;
        none_left = 1'b1;
        for (int i = ALUWIDTH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur_lane)))) begin
                next_lane = LW'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/simd_result_drain.sv
// Shadows one simdcore result batch and serialises masked lanes onto a scalar
// valid/ready memory write port.
module simd_result_drain
    import simd_result_drain_pkg::*;
#(
    parameter int unsigned ALUWIDTH = 16,
    parameter int unsigned ADDRW    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDRW-1:0]              base_addr,
    input  logic [ALUWIDTH-1:0]           lane_mask,
    input  logic [SIMD_WORD*ALUWIDTH-1:0] result_s,
    input  logic [ALUWIDTH-1:0]           iszero_s,
    input  logic [ALUWIDTH-1:0]           overflow_s,
    output logic                          busy,
    output logic                          mem_wr_en,
    output logic [ADDRW-1:0]              mem_addr,
    output logic [SIMD_WORD-1:0]          mem_data,
    input  logic                          mem_ready,
    output logic                          done,
    output logic                          any_overflow,
    output logic                          all_zero
);

    localparam int unsigned LW = lane_idx_w(ALUWIDTH);

    drain_state_e                  state_q, state_d;
    logic [LW-1:0]                 lane_q, lane_d;
    logic [ALUWIDTH-1:0]           mask_q, mask_d;
    logic [ADDRW-1:0]              base_q, base_d;
    logic [SIMD_WORD*ALUWIDTH-1:0] result_q, result_d;
    logic                          busy_q, busy_d;
    logic                          wr_en_q, wr_en_d;
    logic [ADDRW-1:0]              addr_q, addr_d;
    logic [SIMD_WORD-1:0]          data_q, data_d;
    logic                          done_q, done_d;
    logic                          any_ovf_q, any_ovf_d;
    logic                          all_zero_q, all_zero_d;

    logic [ALUWIDTH-1:0]           pick_mask;
    logic [LW-1:0]                 pick_cur;
    logic                          pick_from_start;
    logic [LW-1:0]                 pick_next;
    logic                          pick_none;

    simd_lane_pick #(
        .ALUWIDTH (ALUWIDTH),
        .LW       (LW)
    ) u_pick (
        .mask       (pick_mask),
        .cur_lane   (pick_cur),
        .from_start (pick_from_start),
        .next_lane  (pick_next),
        .none_left  (pick_none)
    );

    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        mask_d          = mask_q;
        base_d          = base_q;
        result_d        = result_q;
        busy_d          = busy_q;
        wr_en_d         = wr_en_q;
        addr_d          = addr_q;
        data_d          = data_q;
        done_d          = 1'b0;
        any_ovf_d       = any_ovf_q;
        all_zero_d      = all_zero_q;
        pick_mask       = mask_q;
        pick_cur        = lane_q;
        pick_from_start = 1'b0;

        unique case (state_q)
            DRAIN_IDLE: begin
                // Pick from the live mask so the first write can issue on the next cycle.
                pick_mask       = lane_mask;
                pick_from_start = 1'b1;
                if (start) begin
                    base_d     = base_addr;
                    mask_d     = lane_mask;
                    result_d   = result_s;
                    any_ovf_d  = |(overflow_s & lane_mask);
                    all_zero_d = &(iszero_s | ~lane_mask);
                    lane_d     = pick_next;
                    if (pick_none) begin
                        state_d = DRAIN_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN_RUN;
                        busy_d  = 1'b1;
                        wr_en_d = 1'b1;
                        addr_d  = base_addr + ADDRW'(SIMD_LANE_STRIDE) * ADDRW'(pick_next);
                        data_d  = result_s[int'(pick_next)*SIMD_WORD +: SIMD_WORD];
                    end
                end
            end
            DRAIN_RUN: begin
                if (wr_en_q && mem_ready) begin
                    if (pick_none) begin
                        state_d = DRAIN_DONE;
                        busy_d  = 1'b0;
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        lane_d = pick_next;
                        addr_d = base_q + ADDRW'(SIMD_LANE_STRIDE) * ADDRW'(pick_next);
                        data_d = result_q[int'(pick_next)*SIMD_WORD +: SIMD_WORD];
                    end
                end
            end
            DRAIN_DONE: begin
                state_d = DRAIN_IDLE;
            end
            default: begin
                state_d = DRAIN_IDLE;
                busy_d  = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DRAIN_IDLE;
            lane_q     <= '0;
            mask_q     <= '0;
            base_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            any_ovf_q  <= 1'b0;
            all_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            mask_q     <= mask_d;
            base_q     <= base_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            any_ovf_q  <= any_ovf_d;
            all_zero_q <= all_zero_d;
        end
    end

    assign busy         = busy_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign done         = done_q;
    assign any_overflow = any_ovf_q;
    assign all_zero     = all_zero_q;

endmodule
